load_buffer: RTL and testbench

- Consumer end of the load/store queue's address-unit port.
- Accepts issued memory ops (A, vj, dest, inst_type) and computes the effective address A+vj.
- Loads: queued in order, executed one at a time through a level-req/pulse-done memory port, extended per type, broadcast on the load CDB.
- Stores: effective address returned to the ROB. Drives the ready flag the queue samples before issuing loads.

---
 rtl/load_buffer_pkg.sv | 56 +++++
 rtl/load_buffer_if.sv | 41 ++++
 rtl/load_buffer_fifo.sv | 77 +++++++
 rtl/load_buffer.sv | 139 +++++++++++++
 tb/tb_load_buffer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/load_buffer_pkg.sv
// Shared types and constants for the load buffer and its FIFO.
package load_buffer_pkg;

  localparam int INST_TYPE_WIDTH = 4;
  localparam int ROB_WIDTH       = 5;

  // Loads occupy LB..LHU, stores SB..SW; both ranges are contiguous.
  localparam logic [INST_TYPE_WIDTH-1:0] LB  = 4'd1;
  localparam logic [INST_TYPE_WIDTH-1:0] LH  = 4'd2;
  localparam logic [INST_TYPE_WIDTH-1:0] LW  = 4'd3;
  localparam logic [INST_TYPE_WIDTH-1:0] LBU = 4'd4;
  localparam logic [INST_TYPE_WIDTH-1:0] LHU = 4'd5;
  localparam logic [INST_TYPE_WIDTH-1:0] SB  = 4'd6;
  localparam logic [INST_TYPE_WIDTH-1:0] SH  = 4'd7;
  localparam logic [INST_TYPE_WIDTH-1:0] SW  = 4'd8;

  localparam logic [ROB_WIDTH-1:0] NULL_TAG = '0;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} lb_state_e;

  typedef struct packed {
    logic [31:0]          addr;
    logic [1:0]           size;
    logic                 sgn;
    logic [ROB_WIDTH-1:0] dest;
  } lb_entry_t;

  function automatic logic [1:0] op_size(input logic [INST_TYPE_WIDTH-1:0] op);
    logic [1:0] s;
    case (op)
      LB, LBU, SB: s = SIZE_BYTE;
      LH, LHU, SH: s = SIZE_HALF;
      default:     s = SIZE_WORD;
    endcase
    return s;
  endfunction

  // Read data arrives LSB-aligned; widen it to 32 bits.
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] size,
                                         input logic sgn);
    logic [31:0] r;
    case (size)
      SIZE_BYTE: r = {{24{sgn & d[7]}}, d[7:0]};
      SIZE_HALF: r = {{16{sgn & d[15]}}, d[15:0]};
      default:   r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_buffer_if.sv
// Issue, memory, CDB and ROB-address signals of the load buffer.
interface load_buffer_if;
  import load_buffer_pkg::*;

  logic                       lsq_en_in;
  logic [31:0]                lsq_A_in;
  logic [31:0]                lsq_vj_in;
  logic [ROB_WIDTH-1:0]       lsq_dest_in;
  logic [INST_TYPE_WIDTH-1:0] lsq_inst_type_in;
  logic                       lbuffer_rdy_out;
  logic                       rob_flush_in;
  logic                       mem_req_out;
  logic [31:0]                mem_addr_out;
  logic [1:0]                 mem_size_out;
  logic                       mem_done_in;
  logic [31:0]                mem_data_in;
  logic                       cdb_en_out;
  logic [ROB_WIDTH-1:0]       cdb_dest_out;
  logic [31:0]                cdb_value_out;
  logic                       rob_addr_en_out;
  logic [ROB_WIDTH-1:0]       rob_addr_dest_out;
  logic [31:0]                rob_addr_out;

  // Environment side: issuing queue, memory controller, ROB.
  modport master (
    output lsq_en_in, lsq_A_in, lsq_vj_in, lsq_dest_in, lsq_inst_type_in,
    output rob_flush_in, mem_done_in, mem_data_in,
    input  lbuffer_rdy_out, mem_req_out, mem_addr_out, mem_size_out,
    input  cdb_en_out, cdb_dest_out, cdb_value_out,
    input  rob_addr_en_out, rob_addr_dest_out, rob_addr_out
  );

  // Load buffer side.
  modport slave (
    input  lsq_en_in, lsq_A_in, lsq_vj_in, lsq_dest_in, lsq_inst_type_in,
    input  rob_flush_in, mem_done_in, mem_data_in,
    output lbuffer_rdy_out, mem_req_out, mem_addr_out, mem_size_out,
    output cdb_en_out, cdb_dest_out, cdb_value_out,
    output rob_addr_en_out, rob_addr_dest_out, rob_addr_out
  );
endinterface

// File: rtl/load_buffer_fifo.sv
// In-order circular buffer of pending loads with clear and fill flags.
module load_fifo
  import load_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           push,
  input  lb_entry_t      push_data,
  input  logic           pop,
  input  logic           clear,
  output lb_entry_t      head_data,
  output logic [PTR_W:0] count,
  output logic           full,
  output logic           almost_full
);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_AFULL = (PTR_W+1)'(DEPTH-1);
  localparam logic [PTR_W:0]   CNT_ONE   = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

  lb_entry_t        mem_q [DEPTH];
  lb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full        = (count_q == CNT_FULL);
  assign almost_full = (count_q >= CNT_AFULL);
  assign count       = count_q;
  assign head_data   = mem_q[head_q];

  // Next pointers/count; a push into a full buffer is dropped, clear wins.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_push = push && !full;
    do_pop  = pop && (count_q != '0);
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + PTR_ONE;
      end
      if (do_pop) head_d = head_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Register buffer state; en low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (en) begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/load_buffer.sv
// Load buffer: address adder, in-order load issue FSM, extension, store address return.
module load_buffer
  import load_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input logic          clk_in,
  input logic          rst_in,
  input logic          rdy_in,
  load_buffer_if.slave bus
);
  lb_state_e            state_q, state_d;
  logic                 mem_req_q, mem_req_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [1:0]           mem_size_q, mem_size_d;
  logic                 cdb_en_q, cdb_en_d;
  logic [ROB_WIDTH-1:0] cdb_dest_q, cdb_dest_d;
  logic [31:0]          cdb_value_q, cdb_value_d;
  logic                 rob_en_q, rob_en_d;
  logic [ROB_WIDTH-1:0] rob_dest_q, rob_dest_d;
  logic [31:0]          rob_addr_q, rob_addr_d;

  logic [31:0]    eff_addr;
  logic           is_load, is_store, flush, push, pop;
  lb_entry_t      push_data, head;
  logic [PTR_W:0] fifo_count;
  logic           fifo_full, fifo_afull;

  assign eff_addr  = bus.lsq_A_in + bus.lsq_vj_in;
  assign is_load   = (bus.lsq_inst_type_in >= LB) && (bus.lsq_inst_type_in <= LHU);
  assign is_store  = (bus.lsq_inst_type_in >= SB) && (bus.lsq_inst_type_in <= SW);
  assign flush     = bus.rob_flush_in;
  assign push      = bus.lsq_en_in && is_load && !flush;
  assign pop       = (state_q == ST_WAIT) && bus.mem_done_in && !flush;
  assign push_data = '{addr: eff_addr,
                       size: op_size(bus.lsq_inst_type_in),
                       sgn:  (bus.lsq_inst_type_in == LB) || (bus.lsq_inst_type_in == LH),
                       dest: bus.lsq_dest_in};

  load_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk(clk_in), .rst(rst_in), .en(rdy_in),
    .push(push), .push_data(push_data), .pop(pop), .clear(flush),
    .head_data(head), .count(fifo_count), .full(fifo_full), .almost_full(fifo_afull)
  );

  // One slot of slack because the issuing queue registers its issue.
  assign bus.lbuffer_rdy_out   = !fifo_afull;
  assign bus.mem_req_out       = mem_req_q;
  assign bus.mem_addr_out      = mem_addr_q;
  assign bus.mem_size_out      = mem_size_q;
  assign bus.cdb_en_out        = cdb_en_q;
  assign bus.cdb_dest_out      = cdb_dest_q;
  assign bus.cdb_value_out     = cdb_value_q;
  assign bus.rob_addr_en_out   = rob_en_q;
  assign bus.rob_addr_dest_out = rob_dest_q;
  assign bus.rob_addr_out      = rob_addr_q;

  // FSM next state, memory request, CDB and store-address pulses.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_size_d  = mem_size_q;
    cdb_en_d    = DISABLE;
    cdb_dest_d  = cdb_dest_q;
    cdb_value_d = cdb_value_q;
    rob_en_d    = DISABLE;
    rob_dest_d  = rob_dest_q;
    rob_addr_d  = rob_addr_q;
    if (bus.lsq_en_in && is_store && !flush) begin
      rob_en_d   = ENABLE;
      rob_dest_d = bus.lsq_dest_in;
      rob_addr_d = eff_addr;
    end
    case (state_q)
      ST_IDLE: if (!flush && fifo_count != '0) begin
        mem_req_d  = ENABLE;
        mem_addr_d = head.addr;
        mem_size_d = head.size;
        state_d    = ST_WAIT;
      end
      ST_WAIT: if (bus.mem_done_in) begin
        mem_req_d = DISABLE;
        state_d   = ST_IDLE;
        if (!flush) begin
          cdb_en_d    = ENABLE;
          cdb_dest_d  = head.dest;
          cdb_value_d = extend(bus.mem_data_in, head.size, head.sgn);
        end
      end else if (flush) begin
        // The read is already in flight; keep req up until it completes.
        state_d = ST_DRAIN;
      end
      ST_DRAIN: if (bus.mem_done_in) begin
        mem_req_d = DISABLE;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered FSM and outputs; pulses clear even while frozen.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= DISABLE;
      mem_addr_q  <= '0;
      mem_size_q  <= '0;
      cdb_en_q    <= DISABLE;
      cdb_dest_q  <= NULL_TAG;
      cdb_value_q <= '0;
      rob_en_q    <= DISABLE;
      rob_dest_q  <= NULL_TAG;
      rob_addr_q  <= '0;
    end else if (!rdy_in) begin
      cdb_en_q <= DISABLE;
      rob_en_q <= DISABLE;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_size_q  <= mem_size_d;
      cdb_en_q    <= cdb_en_d;
      cdb_dest_q  <= cdb_dest_d;
      cdb_value_q <= cdb_value_d;
      rob_en_q    <= rob_en_d;
      rob_dest_q  <= rob_dest_d;
      rob_addr_q  <= rob_addr_d;
    end
  end

  // A load pushed into a full buffer is a protocol error from the issuer.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in)
      assert (!(push && fifo_full)) else $error("load_buffer: load pushed while full, dropped");
  end

endmodule

// File: tb/tb_load_buffer.sv
// Directed bench for load_buffer with scoreboard queues for CDB and ROB-address results.
module tb_load_buffer;
  import load_buffer_pkg::*;

  logic clk, rst, rdy;
  int   total = 0;
  int   bad   = 0;

  typedef struct { logic [ROB_WIDTH-1:0] dest; logic [31:0] val; } res_t;
  typedef struct { logic [31:0] addr; logic [1:0] size; logic [31:0] data; } ld_t;

  res_t cdb_q[$];
  res_t rob_q[$];
  ld_t  lq[$];
  res_t mon_e;

  load_buffer_if bus();

  load_buffer #(.DEPTH(8), .PTR_W(3)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [INST_TYPE_WIDTH-1:0] op, input logic [31:0] d);
    case (op)
      LB:      return {{24{d[7]}}, d[7:0]};
      LH:      return {{16{d[15]}}, d[15:0]};
      LBU:     return {24'h0, d[7:0]};
      LHU:     return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [1:0] msize(input logic [INST_TYPE_WIDTH-1:0] op);
    if (op == LB || op == LBU) return 2'd0;
    if (op == LH || op == LHU) return 2'd1;
    return 2'd2;
  endfunction

  task automatic drive_op(input logic [INST_TYPE_WIDTH-1:0] op, input logic [31:0] a, input logic [31:0] vj,
                          input logic [ROB_WIDTH-1:0] dest);
    bus.lsq_en_in = 1'b1; bus.lsq_inst_type_in = op;
    bus.lsq_A_in = a; bus.lsq_vj_in = vj; bus.lsq_dest_in = dest;
    step();
    bus.lsq_en_in = 1'b0;
  endtask

  // Load whose result must appear on the CDB.
  task automatic issue_ld(input logic [INST_TYPE_WIDTH-1:0] op, input logic [31:0] a, input logic [31:0] vj,
                          input logic [ROB_WIDTH-1:0] dest, input logic [31:0] data);
    lq.push_back('{addr: a + vj, size: msize(op), data: data});
    cdb_q.push_back('{dest: dest, val: model(op, data)});
    drive_op(op, a, vj, dest);
  endtask

  task automatic issue_st(input logic [INST_TYPE_WIDTH-1:0] op, input logic [31:0] a, input logic [31:0] vj,
                          input logic [ROB_WIDTH-1:0] dest);
    rob_q.push_back('{dest: dest, val: a + vj});
    drive_op(op, a, vj, dest);
  endtask

  // Memory model: wait for req, check address/size, answer after 'delay' cycles.
  task automatic serve(input int delay);
    int  guard = 0;
    ld_t e;
    while (bus.mem_req_out !== 1'b1 && guard < 20) begin step(); guard++; end
    chk("req_seen", bus.mem_req_out, 1'b1);
    if (lq.size() == 0) begin
      chk("lq_nonempty", 32'(lq.size()), 1);
      return;
    end
    e = lq.pop_front();
    chk("mem_addr", bus.mem_addr_out, e.addr);
    chk("mem_size", bus.mem_size_out, e.size);
    repeat (delay) begin
      step();
      chk("req_held", bus.mem_req_out, 1'b1);
      chk("addr_held", bus.mem_addr_out, e.addr);
    end
    bus.mem_done_in = 1'b1; bus.mem_data_in = e.data;
    step();
    bus.mem_done_in = 1'b0; bus.mem_data_in = '0;
    chk("req_drop", bus.mem_req_out, 1'b0);
  endtask

  // Every CDB / ROB-address pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cdb_en_out === 1'b1) begin
        if (cdb_q.size() == 0) chk("cdb_unexpected", bus.cdb_en_out, 1'b0);
        else begin
          mon_e = cdb_q.pop_front();
          chk("cdb_dest", bus.cdb_dest_out, mon_e.dest);
          chk("cdb_value", bus.cdb_value_out, mon_e.val);
        end
      end
      if (bus.rob_addr_en_out === 1'b1) begin
        if (rob_q.size() == 0) chk("rob_unexpected", bus.rob_addr_en_out, 1'b0);
        else begin
          mon_e = rob_q.pop_front();
          chk("rob_dest", bus.rob_addr_dest_out, mon_e.dest);
          chk("rob_addr", bus.rob_addr_out, mon_e.val);
        end
      end
    end
  end

  localparam logic [INST_TYPE_WIDTH-1:0] OPS [7] = '{LB, LH, LW, LBU, LHU, LB, LW};
  localparam logic [31:0] DAT [7] = '{32'h00000080, 32'h12347FFF, 32'hCAFEBABE, 32'hFFFFFF81,
                                      32'h0000F00D, 32'h0000007F, 32'h00000000};

  initial begin
    rst = 1'b1; rdy = 1'b1;
    bus.lsq_en_in = 1'b0; bus.lsq_A_in = '0; bus.lsq_vj_in = '0; bus.lsq_dest_in = '0;
    bus.lsq_inst_type_in = '0; bus.rob_flush_in = 1'b0; bus.mem_done_in = 1'b0; bus.mem_data_in = '0;
    step(2);
    rst = 1'b0;
    chk("rst_req", bus.mem_req_out, 1'b0);
    chk("rst_cdb_en", bus.cdb_en_out, 1'b0);
    chk("rst_rob_en", bus.rob_addr_en_out, 1'b0);
    chk("rst_mem_addr", bus.mem_addr_out, 32'h0);
    chk("rst_cdb_val", bus.cdb_value_out, 32'h0);
    chk("rst_rob_addr", bus.rob_addr_out, 32'h0);
    chk("rst_rdy", bus.lbuffer_rdy_out, 1'b1);

    // Sign- and zero-extended byte loads
    issue_ld(LB, 32'h10, 32'h100, 5'd3, 32'h000000F0);
    serve(0);
    step();
    chk("cdb_one_cycle", bus.cdb_en_out, 1'b0);
    issue_ld(LBU, 32'h10, 32'h100, 5'd4, 32'h000000F0);
    serve(1);

    // Store address return, wrapping add
    issue_st(SW, 32'h4, 32'hFFFFFFFE, 5'd5);
    chk("st_no_req", bus.mem_req_out, 1'b0);
    step();
    chk("st_pulse_end", bus.rob_addr_en_out, 1'b0);
    chk("st_no_req2", bus.mem_req_out, 1'b0);

    // Fill with memory stalled; rdy drops at count 7
    for (int i = 0; i < 7; i++) begin
      issue_ld(OPS[i], 32'(i * 4), 32'h1000, 5'(i + 1), DAT[i]);
      chk("rdy_fill", bus.lbuffer_rdy_out, (i + 1) < 7);
    end
    serve(2);
    chk("rdy_back", bus.lbuffer_rdy_out, 1'b1);
    for (int i = 1; i < 7; i++) serve(0);
    step();

    // Flush during WAIT drains the in-flight read
    drive_op(LW, 32'h200, 32'h0, 5'd9);
    step();
    chk("wait_req", bus.mem_req_out, 1'b1);
    bus.rob_flush_in = 1'b1;
    step();
    bus.rob_flush_in = 1'b0;
    chk("drain_req", bus.mem_req_out, 1'b1);
    issue_ld(LH, 32'h30, 32'h0, 5'd10, 32'h00008001);
    chk("drain_addr", bus.mem_addr_out, 32'h200);
    step();
    chk("drain_req2", bus.mem_req_out, 1'b1);
    chk("drain_addr2", bus.mem_addr_out, 32'h200);
    bus.mem_done_in = 1'b1; bus.mem_data_in = 32'h12345678;
    step();
    bus.mem_done_in = 1'b0; bus.mem_data_in = '0;
    chk("drain_done", bus.mem_req_out, 1'b0);
    serve(1);

    // Push coincident with done on a one-entry queue
    issue_ld(LW, 32'h400, 32'h4, 5'd11, 32'h11223344);
    step();
    chk("c_req", bus.mem_req_out, 1'b1);
    chk("c_addr", bus.mem_addr_out, lq[0].addr);
    void'(lq.pop_front());
    bus.mem_done_in = 1'b1; bus.mem_data_in = 32'h11223344;
    issue_ld(LHU, 32'h500, 32'h2, 5'd12, 32'hABCD8001);
    bus.mem_done_in = 1'b0; bus.mem_data_in = '0;
    chk("c_gap", bus.mem_req_out, 1'b0);
    step();
    chk("c_next_req", bus.mem_req_out, 1'b1);
    chk("c_next_addr", bus.mem_addr_out, 32'h502);

    // Freeze mid-WAIT; a done while frozen is ignored
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin bus.mem_done_in = 1'b1; bus.mem_data_in = 32'hDEADBEEF; end
      step();
      bus.mem_done_in = 1'b0; bus.mem_data_in = '0;
      chk("frz_req", bus.mem_req_out, 1'b1);
      chk("frz_addr", bus.mem_addr_out, 32'h502);
    end
    rdy = 1'b1;
    serve(0);

    // Flush coincident with issue and done
    drive_op(LW, 32'h600, 32'h0, 5'd13);
    step();
    chk("f_wait", bus.mem_req_out, 1'b1);
    bus.rob_flush_in = 1'b1; bus.mem_done_in = 1'b1; bus.mem_data_in = 32'h55AA55AA;
    drive_op(LB, 32'h10, 32'h0, 5'd14);
    bus.rob_flush_in = 1'b0; bus.mem_done_in = 1'b0; bus.mem_data_in = '0;
    chk("f_req", bus.mem_req_out, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("f_idle", bus.mem_req_out, 1'b0);
    end
    chk("f_rdy", bus.lbuffer_rdy_out, 1'b1);
    bus.rob_flush_in = 1'b1;
    drive_op(SW, 32'h8, 32'h8, 5'd15);
    bus.rob_flush_in = 1'b0;
    step();

    // Recovery after flush
    issue_ld(LHU, 32'h20, 32'h0, 5'd16, 32'h0000FFFF);
    serve(0);
    step(2);

    chk("cdb_pending", 32'(cdb_q.size()), 0);
    chk("rob_pending", 32'(rob_q.size()), 0);
    chk("lq_pending", 32'(lq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
